writeback_regfile: RTL and testbench
====================================

// Module: writeback_regfile
// PURPOSE
//  Parametrised writeback stage plus architectural register file for the Y86 core.
//  - Registers the W-stage operands each cycle.
//  - Derives the destinations dstE and dstM from icode/rA/rB/cnd.
//  - Commits valE and valM on the next edge.
//  - Serves two combinational read ports with W-stage bypass.
//  - Sits between memory stage and decode; usable by both sequential and pipelined cores.
// PARAMETERS
//  DATA_W    64   register/data width in bits
//  NREGS     15   architectural registers; indices 0..NREGS-1; index 15 = RNONE
//  RSP_IDX   4    index of %rsp
//  RSP_INIT  0    reset value of %rsp (all other registers reset to 0)
// PORTS
//  clk     in   1       rising-edge clock
//  rst     in   1       asynchronous, active-high reset
//  stall   in   1       hold W register (no capture, no commit)
//  bubble  in   1       load W register with nop (icode=1)
//  icode   in   4       instruction code entering W
//  rA      in   4       rA field
//  rB      in   4       rB field
//  cnd     in   1       condition flag (cmovXX)
//  valE    in   DATA_W  ALU result
//  valM    in   DATA_W  memory read data
//  srcA    in   4       read port A index (15 = none)
//  srcB    in   4       read port B index (15 = none)
//  rdA     out  DATA_W  read data A
//  rdB     out  DATA_W  read data B
//  w_dstE  out  4       registered dstE of the instruction in W
//  w_dstM  out  4       registered dstM of the instruction in W
//  halted  out  1       sticky halt status
// BEHAVIOUR
//  Reset (async, immediate):
//   - all registers = 0, except reg[RSP_IDX] = RSP_INIT
//   - W register = nop: w_dstE = w_dstM = 15, W values = 0
//   - halted = 0
//  Destination decode (combinational, on inputs):
//   - dstE = rB for icode 3 and 6; rB for icode 2 only if cnd = 1; else 15
//   - dstE = RSP_IDX for icode 8, 9, A, B
//   - dstM = rA for icode 5 and B; else 15
//   - all other icodes: dstE = dstM = 15
//  Edge n, capture:
//   - if !stall: W <= {dstE, dstM, valE, valM}; bubble forces dstE = dstM = 15
//   - if stall and bubble are both high: stall wins
//  Edge n+1, commit, from W contents (not gated by stall, since W holds under stall):
//   - reg[w_dstE] <= W.valE
//   - reg[w_dstM] <= W.valM
//   - each write occurs only if its index < NREGS
//   - index 15, or any index >= NREGS, is silently dropped
//   - w_dstE == w_dstM (popq %rsp): the valM write wins
//   - writes are idempotent, so re-committing under stall is harmless
//  Reads (combinational):
//   - rdX = 0 if srcX == 15 or srcX >= NREGS
//   - else W.valM if srcX == w_dstM
//   - else W.valE if srcX == w_dstE
//   - else reg[srcX]
//   - the M bypass has priority over the E bypass
//   - net effect: a result is readable in the cycle after capture, before commit
//  Halt:
//   - icode 0 captured into W sets halted = 1
//   - halted clears only on rst
//   - captures and commits continue while halted
//  Width: all data paths DATA_W; no truncation or extension inside the block.
// TESTING
//  1. rst with RSP_INIT=256 -> rdA(srcA=4) = 256; rdB(srcB=1) = 0; w_dstE = w_dstM = 15.
//  2. icode=3, rB=2, valE=20, edge -> rdA(srcA=2) = 20 via bypass at once;
//     after next edge with bubble -> reg[2] = 20.
//  3. icode=2, rB=1, valE=55: cnd=0 -> reg[1] unchanged; cnd=1 -> reg[1] = 55.
//  4. icode=B, rA=4, valE=0x108, valM=0x77 -> reg[4] = 0x77 (M wins);
//     icode=B, rA=0 -> reg[0] = 0x77 and reg[4] = 0x108.
//  5. stall held 3 cycles with new inputs -> W and registers unchanged;
//     stall+bubble together -> W keeps the old instruction.
//  6. icode=0 captured -> halted = 1 and stays 1; rst mid-sequence -> all registers and halted reset at once.

Source files
------------

// File: rtl/writeback_regfile.sv
// Purpose: Y86 writeback stage register (W) plus architectural register file with W-stage read bypass.
// Latency: W captures on edge n; commit to the file on edge n+1; results are readable through bypass during the cycle after capture.
// Backpressure: stall holds W and blocks capture, while commit from W continues harmlessly; bubble loads a nop; stall wins over bubble.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   stall, bubble        W register hold / nop-insert controls
//   icode, rA, rB, cnd   instruction fields that decide the destinations
//   valE, valM           ALU result and memory read data entering W
//   srcA/srcB -> rdA/rdB two combinational read ports (15 = none, reads 0)
//   w_dstE, w_dstM       destinations of the instruction held in W
//   halted               sticky, set when a halt (icode 0) is captured
module writeback_regfile #(
    parameter int               DATA_W   = 64,
    parameter int               NREGS    = 15,
    parameter int               RSP_IDX  = 4,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              bubble,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] rdA,
    output logic [DATA_W-1:0] rdB,
    output logic [3:0]        w_dstE,
    output logic [3:0]        w_dstM,
    output logic              halted
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP4  = 4'(RSP_IDX);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [3:0]        r_w_dstE;
    logic [3:0]        r_w_dstM;
    logic [DATA_W-1:0] r_w_valE;
    logic [DATA_W-1:0] r_w_valM;
    logic              r_halted;

    logic [3:0]        w_dec_dstE;
    logic [3:0]        w_dec_dstM;

    // Destination decode on the incoming instruction.
    always_comb begin
        w_dec_dstE = RNONE;
        w_dec_dstM = RNONE;
        case (icode)
            4'h2: begin
                // cmovXX only writes when the condition holds
                if (cnd) w_dec_dstE = rB;
            end
            4'h3, 4'h6: w_dec_dstE = rB;
            4'h8, 4'h9, 4'hA: w_dec_dstE = RSP4;
            4'hB: begin
                w_dec_dstE = RSP4;
                w_dec_dstM = rA;
            end
            4'h5: w_dec_dstM = rA;
            default: ;
        endcase
    end

    // W register and sticky halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_dstE <= RNONE;
            r_w_dstM <= RNONE;
            r_w_valE <= '0;
            r_w_valM <= '0;
            r_halted <= 1'b0;
        end else if (!stall) begin
            r_w_dstE <= bubble ? RNONE : w_dec_dstE;
            r_w_dstM <= bubble ? RNONE : w_dec_dstM;
            r_w_valE <= valE;
            r_w_valM <= valM;
            // a bubble is a nop, so a halt it replaces never reaches W
            if (!bubble && icode == 4'h0) r_halted <= 1'b1;
        end
    end

    // Commit from W. Indices outside 0..NREGS-1 (including 15) match no
    // entry and are dropped; M is checked first so popq %rsp keeps valM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (r_w_dstM == 4'(i))      r_regs[i] <= r_w_valM;
                else if (r_w_dstE == 4'(i)) r_regs[i] <= r_w_valE;
            end
        end
    end

    // Read with W bypass; M bypass beats E bypass, matching commit priority.
    function automatic logic [DATA_W-1:0] read_port(input logic [3:0] src);
        logic [DATA_W-1:0] v;
        v = '0;
        if (32'(src) < NREGS) begin
            if (src == r_w_dstM)      v = r_w_valM;
            else if (src == r_w_dstE) v = r_w_valE;
            else begin
                for (int i = 0; i < NREGS; i++) begin
                    if (src == 4'(i)) v = r_regs[i];
                end
            end
        end
        return v;
    endfunction

    always_comb begin
        rdA = read_port(srcA);
        rdB = read_port(srcB);
    end

    assign w_dstE = r_w_dstE;
    assign w_dstM = r_w_dstM;
    assign halted = r_halted;

endmodule

// File: tb/tb_writeback_regfile.sv
// Purpose: directed scoreboard bench for writeback_regfile.
// Latency: stimulus and checks advance one clock per instruction; each check settles 2 time units.
// Backpressure: stall/bubble exercised directly by the stimulus.
module tb_writeback_regfile;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall, bubble, cnd;
    logic [3:0]        icode, rA, rB, srcA, srcB;
    logic [DATA_W-1:0] valE, valM, rdA, rdB;
    logic [3:0]        w_dstE, w_dstM;
    logic              halted;

    writeback_regfile #(
        .DATA_W(DATA_W), .NREGS(15), .RSP_IDX(4), .RSP_INIT(64'd256)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
        .rdA(rdA), .rdB(rdB), .w_dstE(w_dstE), .w_dstM(w_dstM),
        .halted(halted)
    );

    always #20 clk = ~clk;

    typedef struct {
        string             name;
        logic [DATA_W-1:0] rdA;
        logic [DATA_W-1:0] rdB;
        logic [3:0]        dstE;
        logic [3:0]        dstM;
        logic              halted;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Monitor: whenever an expectation is queued, sample the DUT outputs
    // one time unit later and compare.
    initial begin
        exp_t e;
        forever begin
            wait (sb_q.size() != 0);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (rdA === e.rdA && rdB === e.rdB && w_dstE === e.dstE &&
                w_dstM === e.dstM && halted === e.halted) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got rdA=%h rdB=%h dstE=%h dstM=%h halted=%b, want rdA=%h rdB=%h dstE=%h dstM=%h halted=%b",
                         e.name, rdA, rdB, w_dstE, w_dstM, halted,
                         e.rdA, e.rdB, e.dstE, e.dstM, e.halted);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] sa, input logic [3:0] sb,
                       input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb,
                       input logic [3:0] edE, input logic [3:0] edM, input logic eh);
        exp_t e;
        srcA = sa;
        srcB = sb;
        e.name = name; e.rdA = ea; e.rdB = eb;
        e.dstE = edE; e.dstM = edM; e.halted = eh;
        sb_q.push_back(e);
        #2;
    endtask

    // Present one instruction and clock it in.
    task automatic cyc(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] m,
                       input logic st, input logic bu);
        icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
        stall = st; bubble = bu;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        cyc(4'h1, 4'hF, 4'hF, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
        valE = '0; valM = '0; stall = 1'b0; bubble = 1'b0;
        srcA = 4'hF; srcB = 4'hF;

        // 1. reset state
        chk("reset", 4'd4, 4'd1, 64'd256, 64'd0, 4'hF, 4'hF, 1'b0);
        rst = 1'b0;

        // 2. irmovq to r2: bypass then commit
        cyc(4'h3, 4'hF, 4'd2, 1'b0, 64'd20, 64'd0, 1'b0, 1'b0);
        chk("irmov_bypass", 4'd2, 4'hF, 64'd20, 64'd0, 4'd2, 4'hF, 1'b0);
        cyc(4'h3, 4'hF, 4'd9, 1'b0, 64'd99, 64'd0, 1'b0, 1'b1);
        chk("irmov_commit", 4'd2, 4'd9, 64'd20, 64'd0, 4'hF, 4'hF, 1'b0);

        // 3. cmov to r1, condition false then true
        cyc(4'h2, 4'hF, 4'd1, 1'b0, 64'd55, 64'd0, 1'b0, 1'b0);
        chk("cmov_nc_w", 4'd1, 4'd4, 64'd0, 64'd256, 4'hF, 4'hF, 1'b0);
        nop();
        chk("cmov_nc_reg", 4'd1, 4'hF, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0);
        cyc(4'h2, 4'hF, 4'd1, 1'b1, 64'd55, 64'd0, 1'b0, 1'b0);
        chk("cmov_c_byp", 4'd1, 4'hF, 64'd55, 64'd0, 4'd1, 4'hF, 1'b0);
        nop();
        chk("cmov_c_reg", 4'd1, 4'hF, 64'd55, 64'd0, 4'hF, 4'hF, 1'b0);

        // 4. popq %rsp: M wins on both bypass and commit
        cyc(4'hB, 4'd4, 4'hF, 1'b0, 64'h108, 64'h77, 1'b0, 1'b0);
        chk("pop_rsp_byp", 4'd4, 4'hF, 64'h77, 64'd0, 4'd4, 4'd4, 1'b0);
        nop();
        chk("pop_rsp_reg", 4'd4, 4'hF, 64'h77, 64'd0, 4'hF, 4'hF, 1'b0);
        cyc(4'hB, 4'd0, 4'hF, 1'b0, 64'h108, 64'h77, 1'b0, 1'b0);
        chk("pop_r0_byp", 4'd4, 4'd0, 64'h108, 64'h77, 4'd4, 4'd0, 1'b0);
        nop();
        chk("pop_r0_reg", 4'd4, 4'd0, 64'h108, 64'h77, 4'hF, 4'hF, 1'b0);

        // call writes %rsp from valE; mrmovq writes rA from valM
        cyc(4'h8, 4'hF, 4'hF, 1'b0, 64'h100, 64'h5, 1'b0, 1'b0);
        chk("call_byp", 4'd4, 4'hF, 64'h100, 64'd0, 4'd4, 4'hF, 1'b0);
        cyc(4'h5, 4'd9, 4'd3, 1'b0, 64'h1, 64'hAB, 1'b0, 1'b0);
        chk("mrmov_byp", 4'd9, 4'd4, 64'hAB, 64'h100, 4'hF, 4'd9, 1'b0);
        nop();
        chk("mrmov_reg", 4'd9, 4'd3, 64'hAB, 64'd0, 4'hF, 4'hF, 1'b0);

        // 5. stall holds W across new inputs; stall beats bubble
        cyc(4'h6, 4'd8, 4'd3, 1'b0, 64'h33, 64'd0, 1'b0, 1'b0);
        chk("opq_byp", 4'd3, 4'd5, 64'h33, 64'd0, 4'd3, 4'hF, 1'b0);
        cyc(4'h3, 4'hF, 4'd5, 1'b0, 64'h55, 64'd0, 1'b1, 1'b0);
        chk("stall1", 4'd3, 4'd5, 64'h33, 64'd0, 4'd3, 4'hF, 1'b0);
        cyc(4'h5, 4'd6, 4'hF, 1'b0, 64'd0, 64'h66, 1'b1, 1'b0);
        chk("stall2", 4'd3, 4'd6, 64'h33, 64'd0, 4'd3, 4'hF, 1'b0);
        cyc(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
        chk("stall3_nohalt", 4'd3, 4'd5, 64'h33, 64'd0, 4'd3, 4'hF, 1'b0);
        cyc(4'h3, 4'hF, 4'd7, 1'b0, 64'h77, 64'd0, 1'b1, 1'b1);
        chk("stall_bubble", 4'd3, 4'd7, 64'h33, 64'd0, 4'd3, 4'hF, 1'b0);
        nop();
        chk("after_stall", 4'd3, 4'd5, 64'h33, 64'd0, 4'hF, 4'hF, 1'b0);
        chk("src_none", 4'hF, 4'd3, 64'd0, 64'h33, 4'hF, 4'hF, 1'b0);

        // 6. halt: bubbled halt ignored, real halt sticky, commits continue
        cyc(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
        chk("bubble_halt", 4'd3, 4'hF, 64'h33, 64'd0, 4'hF, 4'hF, 1'b0);
        cyc(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("halt_set", 4'd3, 4'hF, 64'h33, 64'd0, 4'hF, 4'hF, 1'b1);
        cyc(4'h3, 4'hF, 4'd6, 1'b0, 64'h99, 64'd0, 1'b0, 1'b0);
        chk("halt_byp", 4'd6, 4'hF, 64'h99, 64'd0, 4'd6, 4'hF, 1'b1);
        nop();
        chk("halt_commit", 4'd6, 4'd2, 64'h99, 64'd20, 4'hF, 4'hF, 1'b1);

        // async reset mid-cycle
        cyc(4'h3, 4'hF, 4'd2, 1'b0, 64'h44, 64'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_a", 4'd4, 4'd2, 64'd256, 64'd0, 4'hF, 4'hF, 1'b0);
        chk("rst_mid_b", 4'd6, 4'd9, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0);
        rst = 1'b0;
        nop();
        chk("post_rst", 4'd3, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0);

        // drain scoreboard with a bound
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) #1;
        if (sb_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
            n_checks++;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
